// File: rtl/gin_multicast_buffer.sv
// GIN multicast endpoint: accepts tagged transfers inside a scan-loaded
// inclusive [id_lo, id_hi] range into a small elastic FIFO for the PE.
module gin_multicast_buffer #(
  parameter  int ID_LEN    = 4,
  parameter  int VALUE_LEN = 32,
  parameter  int DEPTH     = 2,
  localparam int CNT_LEN   = $clog2(DEPTH) + 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 set_id,
  input  logic [ID_LEN-1:0]    id_in,
  output logic [ID_LEN-1:0]    id_out,
  input  logic [ID_LEN-1:0]    tag,
  input  logic                 enable_in,
  output logic                 ready_out,
  input  logic [VALUE_LEN-1:0] value_in,
  output logic                 enable_out,
  input  logic                 ready_in,
  output logic [VALUE_LEN-1:0] value_out,
  output logic [CNT_LEN-1:0]   count
);

  localparam int PTR_W = $clog2(DEPTH);

  logic [ID_LEN-1:0]    id_lo_q, id_lo_d;
  logic [ID_LEN-1:0]    id_hi_q, id_hi_d;
  logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
  logic [CNT_LEN-1:0]   count_q, count_d;
  logic [VALUE_LEN-1:0] mem_q [DEPTH];
  logic [VALUE_LEN-1:0] mem_d [DEPTH];

  logic match;
  logic full;
  logic push;
  logic pop;

  // ready_out deliberately ignores a same-cycle pop so the upstream path stays registered-only
  always_comb begin
    match      = (tag >= id_lo_q) && (tag <= id_hi_q);
    full       = (count_q == CNT_LEN'(DEPTH));
    ready_out  = match ? ~full : 1'b1;
    push       = enable_in & match & ~full;
    enable_out = (count_q != '0);
    pop        = enable_out & ready_in;
    value_out  = enable_out ? mem_q[rd_ptr_q] : '0;
    id_out     = id_hi_q;
    count      = count_q;
  end

  always_comb begin
    id_lo_d  = id_lo_q;
    id_hi_d  = id_hi_q;
    rd_ptr_d = rd_ptr_q;
    wr_ptr_d = wr_ptr_q;
    count_d  = count_q;
    mem_d    = mem_q;

    if (set_id) begin
      id_hi_d = id_lo_q;
      id_lo_d = id_in;
    end

    if (push) begin
      mem_d[wr_ptr_q] = value_in;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end

    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end

    case ({push, pop})
      2'b10:   count_d = count_q + CNT_LEN'(1);
      2'b01:   count_d = count_q - CNT_LEN'(1);
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      id_lo_q  <= '0;
      id_hi_q  <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      id_lo_q  <= id_lo_d;
      id_hi_q  <= id_hi_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
    end
  end

  // Storage needs no reset: value_out is gated to zero while the FIFO is empty
  always_ff @(posedge clk) begin
    if (!rst) begin
      mem_q <= mem_d;
    end
  end

endmodule

// File: tb/tb_gin_multicast_buffer.sv
// Self-checking bench for gin_multicast_buffer: queue-based reference model
// compared every cycle, plus directed literal expectations.
module tb_gin_multicast_buffer;

  localparam int ID_LEN    = 4;
  localparam int VALUE_LEN = 32;
  localparam int DEPTH     = 2;
  localparam int CNT_LEN   = $clog2(DEPTH) + 1;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 set_id;
  logic [ID_LEN-1:0]    id_in;
  logic [ID_LEN-1:0]    id_out;
  logic [ID_LEN-1:0]    tag;
  logic                 enable_in;
  logic                 ready_out;
  logic [VALUE_LEN-1:0] value_in;
  logic                 enable_out;
  logic                 ready_in;
  logic [VALUE_LEN-1:0] value_out;
  logic [CNT_LEN-1:0]   count;

  int errors = 0;
  int checks = 0;
  bit checkEn = 1'b0;

  // Reference model state
  logic [VALUE_LEN-1:0] mQueue[$];
  int unsigned          mLo = 0;
  int unsigned          mHi = 0;

  gin_multicast_buffer #(
    .ID_LEN(ID_LEN),
    .VALUE_LEN(VALUE_LEN),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .set_id(set_id),
    .id_in(id_in),
    .id_out(id_out),
    .tag(tag),
    .enable_in(enable_in),
    .ready_out(ready_out),
    .value_in(value_in),
    .enable_out(enable_out),
    .ready_in(ready_in),
    .value_out(value_out),
    .count(count)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Inputs change just after a rising edge and hold until the next one
  task automatic applyStimulus(input int cycles);
    repeat (cycles) @(posedge clk);
    #1;
  endtask

  function automatic bit modelMatch();
    return (int'(tag) >= mLo) && (int'(tag) <= mHi);
  endfunction

  always @(posedge clk) begin
    bit doPush;
    bit doPop;
    if (rst) begin
      mQueue.delete();
      mLo = 0;
      mHi = 0;
    end else begin
      doPush = enable_in && modelMatch() && (mQueue.size() < DEPTH);
      doPop  = (mQueue.size() > 0) && ready_in;
      if (set_id) begin
        mHi = mLo;
        mLo = int'(id_in);
      end
      if (doPop) void'(mQueue.pop_front());
      if (doPush) mQueue.push_back(value_in);
    end
  end

  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("enable_out", 32'(enable_out), 32'(mQueue.size() != 0));
      checkOutput("value_out", value_out, (mQueue.size() != 0) ? mQueue[0] : 32'h0);
      checkOutput("count", 32'(count), 32'(mQueue.size()));
      checkOutput("id_out", 32'(id_out), mHi);
      checkOutput("ready_out", 32'(ready_out),
                  modelMatch() ? 32'(mQueue.size() < DEPTH) : 32'h1);
    end
  end

  initial begin
    rst = 1'b1; set_id = 1'b0; id_in = '0; tag = '0;
    enable_in = 1'b0; value_in = '0; ready_in = 1'b0;
    applyStimulus(1);
    checkEn = 1'b1;
    applyStimulus(1);
    rst = 1'b0;
    checkOutput("rst_enable_out", 32'(enable_out), 32'h0);
    checkOutput("rst_value_out", value_out, 32'h0);
    checkOutput("rst_count", 32'(count), 32'h0);
    checkOutput("rst_id_out", 32'(id_out), 32'h0);
    checkOutput("rst_ready_out", 32'(ready_out), 32'h1);

    // Scan load: hi value first, then lo value
    set_id = 1'b1; id_in = 4'd5;
    applyStimulus(1);
    id_in = 4'd3;
    applyStimulus(1);
    set_id = 1'b0;
    checkOutput("scan_id_out", 32'(id_out), 32'h5);

    tag = 4'd4; enable_in = 1'b1; value_in = 32'h55;
    checkOutput("tag4_ready", 32'(ready_out), 32'h1);
    applyStimulus(1);
    checkOutput("tag4_push_count", 32'(count), 32'h1);
    tag = 4'd6; value_in = 32'h66;
    checkOutput("tag6_ready", 32'(ready_out), 32'h1);
    applyStimulus(1);
    checkOutput("tag6_no_push", 32'(count), 32'h1);
    enable_in = 1'b0; ready_in = 1'b1;
    applyStimulus(1);
    ready_in = 1'b0;
    checkOutput("drain_count", 32'(count), 32'h0);

    // Fill to full, third push must be dropped
    tag = 4'd4; enable_in = 1'b1; value_in = 32'hA1;
    applyStimulus(1);
    value_in = 32'hA2;
    applyStimulus(1);
    checkOutput("full_count", 32'(count), 32'h2);
    checkOutput("full_ready", 32'(ready_out), 32'h0);
    value_in = 32'hA3;
    applyStimulus(1);
    checkOutput("full_ignore_count", 32'(count), 32'h2);
    checkOutput("full_head", value_out, 32'hA1);
    enable_in = 1'b0; ready_in = 1'b1;
    applyStimulus(1);
    checkOutput("pop_second", value_out, 32'hA2);
    applyStimulus(1);
    checkOutput("pop_empty_en", 32'(enable_out), 32'h0);
    checkOutput("pop_empty_val", value_out, 32'h0);
    ready_in = 1'b0;

    // Simultaneous push and pop at count=1
    enable_in = 1'b1; value_in = 32'hB1;
    applyStimulus(1);
    value_in = 32'hB2; ready_in = 1'b1;
    applyStimulus(1);
    checkOutput("pushpop_count", 32'(count), 32'h1);
    checkOutput("pushpop_value", value_out, 32'hB2);
    enable_in = 1'b0;
    applyStimulus(1);

    // Continuous stream through the wrapping pointers
    enable_in = 1'b1; ready_in = 1'b1;
    for (int i = 0; i < 8; i++) begin
      value_in = 32'h10 + 32'(i);
      applyStimulus(1);
      checkOutput("stream_value", value_out, 32'h10 + 32'(i));
    end
    enable_in = 1'b0;
    applyStimulus(1);
    checkOutput("stream_empty", 32'(enable_out), 32'h0);

    // Reset mid-operation with a matching push in the reset cycle
    ready_in = 1'b0; enable_in = 1'b1; value_in = 32'hC1;
    applyStimulus(1);
    value_in = 32'hC2;
    applyStimulus(1);
    checkOutput("pre_rst_count", 32'(count), 32'h2);
    rst = 1'b1; value_in = 32'hC3;
    applyStimulus(1);
    rst = 1'b0; enable_in = 1'b0;
    checkOutput("mid_rst_count", 32'(count), 32'h0);
    checkOutput("mid_rst_enable", 32'(enable_out), 32'h0);
    checkOutput("mid_rst_id_out", 32'(id_out), 32'h0);

    // Inverted range matches nothing
    set_id = 1'b1; id_in = 4'd2;
    applyStimulus(1);
    id_in = 4'd7;
    applyStimulus(1);
    set_id = 1'b0; tag = 4'd5; enable_in = 1'b1; value_in = 32'hD1;
    applyStimulus(1);
    checkOutput("inverted_no_push", 32'(count), 32'h0);
    checkOutput("inverted_ready", 32'(ready_out), 32'h1);
    enable_in = 1'b0;
    applyStimulus(2);

    checkEn = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/gin_multicast_buffer.md
Name: gin_multicast_buffer

Overview:
- Next-generation GIN multicast endpoint. Each node holds an inclusive tag range [id_lo, id_hi], loaded through the shared ID scan chain.
- Any tagged transfer whose tag falls in the range is accepted into a small elastic FIFO and then delivered downstream under a ready/enable handshake.
- The FIFO decouples the GIN bus from a stalled PE, so a busy consumer no longer throttles the multicast combinationally.
- Sits between a GIN bus tap and a PE input port. One instance per PE.

Parameters:
- ID_LEN, 4, width of tag and range bounds.
- VALUE_LEN, 32, payload width.
- DEPTH, 2, FIFO entries; power of two, ≥2.
- CNT_LEN, $clog2(DEPTH)+1, width of the occupancy output (derived; do not override).

Ports:
- clk  in  1  clock.
- rst  in  1  synchronous reset, active-high.
- set_id  in  1  scan-chain shift enable.
- id_in  in  ID_LEN  scan-chain input.
- id_out  out  ID_LEN  scan-chain output, equal to id_hi.
- tag  in  ID_LEN  destination tag of the current bus transfer.
- enable_in  in  1  upstream valid.
- ready_out  out  1  upstream ready.
- value_in  in  VALUE_LEN  upstream payload.
- enable_out  out  1  downstream valid.
- ready_in  in  1  downstream ready.
- value_out  out  VALUE_LEN  downstream payload.
- count  out  CNT_LEN  current FIFO occupancy.

Behaviour:
- Interface: one clock, clk; reset is synchronous and active-high, named rst.
- Reset (rst=1 at posedge):
  - id_lo, id_hi <= 0.
  - FIFO emptied: rd_ptr, wr_ptr, count <= 0.
  - After reset: enable_out=0, value_out=0, count=0, id_out=0, ready_out=1.
  - Reset mid-operation discards all buffered entries; no transfer completes in the reset cycle.
- Scan chain:
  - set_id=1 at posedge: id_hi <= id_lo and id_lo <= id_in, so this is a two-stage shift per node.
  - Configuration is loaded hi-value first, then lo-value.
  - set_id has no effect on FIFO contents.
- Match (combinational): match = (tag >= id_lo) && (tag <= id_hi), unsigned compare.
  - If id_lo > id_hi, the node matches nothing.
- ready_out = match ? ~full : 1.
  - Non-matching nodes do not block the multicast.
  - ready_out does not look at a same-cycle pop; this keeps the upstream path registered-only.
- Push when enable_in & match & ~full. value_in is written at wr_ptr, and wr_ptr advances modulo DEPTH.
- Pop when enable_out & ready_in. rd_ptr advances modulo DEPTH.
- enable_out = (count != 0).
- value_out = enable_out ? mem[rd_ptr] : 0 (zero when empty).
- Latency: a push at edge N is visible as enable_out=1 after edge N. There is no combinational pass-through from upstream to downstream.
- count at each posedge:
  - +1 on push only.
  - -1 on pop only.
  - unchanged on simultaneous push and pop, or on neither.
- Full (count==DEPTH):
  - ready_out=0 for a matching tag. enable_in is ignored and no write occurs.
  - A pop in the same cycle still happens. ready_out rises the following cycle.
- Empty: a push and a pop cannot occur in the same cycle, since enable_out=0.
- Pointers wrap via ID-free modulo DEPTH arithmetic, so no gap appears at wrap-around.
- Ordering: strict FIFO; entries leave in push order.

Test Plan:
- Reset: rst=1 for 2 cycles, then 0 → enable_out=0, value_out=0, count=0, id_out=0, ready_out=1.
- Scan load: set_id=1 for 2 cycles with id_in=5 then 3 → id_lo=3, id_hi=5, id_out=5.
  - tag=4 gives ready_out=1 and a push.
  - tag=6 gives no push and ready_out=1.
- Fill/full, with range [3,5], ready_in=0:
  - Push 0xA1 then 0xA2 → count=2, and ready_out=0 for tag=4.
  - A third push of 0xA3 is ignored.
  - Then ready_in=1 → value_out reads 0xA1, then 0xA2, then enable_out=0. 0xA3 is never seen.
- Simultaneous push/pop: hold count=1, drive a matching push of 0xB2 and ready_in=1 in the same cycle → count stays 1 and value_out becomes 0xB2.
- Wrap-around, DEPTH=2: stream 0x10..0x17 with ready_in=1 and enable_in=1 continuous → output reads 0x10..0x17 in order, one per cycle after a 1-cycle latency.
- Reset mid-operation: count=2, assert rst for 1 cycle → count=0, enable_out=0, ids cleared, and a matching push in the reset cycle is dropped.
